regfile_sb: RTL
===============

# regfile_sb

Parametrised successor of the 16×16 two-read/one-write register file: configurable data width, depth and read-port count, R[PC_REG] aliased to the live PC, optional write-to-read bypass, and a per-register pending scoreboard for multi-cycle results (loads, multiply). Sits between decode and execute in the datapath. Decode reserves destinations and reads operands here; writeback retires them here. The `stall` output drives the pipeline hazard unit.

## Interface
- `DATA_W`, 16, register and PC width
- `ADDR_W`, 4, address width; depth = 2**ADDR_W
- `NUM_RD`, 2, number of read ports
- `PC_REG`, 2**ADDR_W-1, index that reads back `pc` and is never written
- `BYPASS`, 1, 1 = same-cycle write data forwarded to reads

Ports:
- `clk` in 1: single clock; all state updates on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `pc` in DATA_W: current program counter
- `rd_en` in NUM_RD: port i is consuming an operand this cycle
- `rd_addr` in NUM_RD*ADDR_W: packed read addresses, port i at [i*ADDR_W +: ADDR_W]
- `rd_data` out NUM_RD*DATA_W: packed read data
- `rd_busy` out NUM_RD: addressed register is pending
- `we` in 1, `wa` in ADDR_W, `wd` in DATA_W: write port
- `rsv_en` in 1, `rsv_addr` in ADDR_W: reserve a destination
- `rsv_ok` out 1: reservation accepted
- `pending` out 2**ADDR_W: scoreboard vector
- `stall` out 1: OR over i of (`rd_en[i]` & `rd_busy[i]`)

## Operation
- Reset (async assert, sync-safe release): all registers 0 and `pending` 0. Outputs settle to `rd_data`=0 (or `pc` for PC_REG reads), `rd_busy`=0, `stall`=0.
- Reads are combinational.
  - `rd_addr`==PC_REG returns `pc` and busy=0.
  - If BYPASS=1, `we`, and `wa`==`rd_addr`!=PC_REG, the read returns `wd`.
  - Otherwise the read returns the stored value.
- Write: on the clock edge when `we`, `R[wa]`←`wd` and `pending[wa]`←0. A write to PC_REG is dropped, with no state change.
- Reserve: `rsv_ok` = `rsv_en` & !`pending[rsv_addr]` & `rsv_addr`!=PC_REG.
  - When `rsv_ok` is 1, `pending[rsv_addr]`←1 at the edge.
  - A refused reservation (WAW on a pending register, or a PC_REG target) changes nothing. Decode must hold the instruction.
- `rd_busy[i]` = `pending[rd_addr[i]]`, except:
  - it is 0 when BYPASS=1 and a same-cycle write to that address is present;
  - it is always 0 for PC_REG.
- Same-cycle write and reserve to the same address: write data is stored and `pending` ends at 1 (the new reservation wins). Here `rsv_ok` is evaluated on the pre-edge `pending`, with the write clear applied first. A pending register being retired is therefore re-reservable in its retire cycle.
- Multiple read ports may hit the same address; each returns identical data and busy.
- Reads of out-of-range addresses cannot occur (depth = 2**ADDR_W).

## Timing
- Read latency: 0 cycles (combinational from `rd_addr`, `pc`, `we`/`wa`/`wd`).
- Write-to-read latency: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
- Reserve-to-busy: `pending` is visible the cycle after `rsv_ok`.
- Reset mid-operation clears data and scoreboard immediately. A write on the same edge as reset deassertion is ignored.

## Structure
- Shared package `regfile_pkg`:
  - default DATA_W/ADDR_W;
  - `PC_IDX` constant;
  - typedefs `reg_addr_t`, `reg_data_t`.
- Sub-module `rf_scoreboard` holds the `pending` vector, `rsv_ok` logic, write-clear and per-port busy lookup.
- Parent holds the storage array, read muxing, PC alias and bypass.

## Test plan
- Reset then read all addresses with `pc`=16'h0004 -> R0..R14 read 0, R15 reads 4, `pending`=0, `stall`=0.
- Write R3=9, R6=5, then read port0=R3 and port1=R6 -> 9 and 5. With `we` R3=7 held during the read -> 7 with BYPASS=1, 9 with BYPASS=0.
- Write R15=16'hFFFF, `pc`=8 -> R15 still reads 8 and the storage is unchanged.
- Reserve R4 (`rsv_ok`=1), then read R4 with `rd_en`=1 -> `rd_busy`=1 and `stall`=1. Reserve R4 again -> `rsv_ok`=0. Write R4=12 -> same cycle busy=0 (BYPASS=1) and data=12, next cycle `pending[4]`=0.
- Same-cycle write R5=3 and reserve R5 while R5 is pending -> `rsv_ok`=1, next cycle R5=3 and `pending[5]`=1. Reserve R15 -> `rsv_ok`=0.
- Set R2=1 and `pending[7]`=1, pulse `rst_n` low mid-cycle -> immediately R2 reads 0 and `pending`=0. Repeat with NUM_RD=3, DATA_W=32: three ports read distinct values correctly.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned PC_IDX     = (2 ** ADDR_W_DEF) - 1;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-result scoreboard: reservation grant, writeback clear and per-port busy lookup.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned PC_REG = (2 ** ADDR_W) - 1,
  parameter int unsigned BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic [ADDR_W-1:0]        i_wa,
  input  logic                     i_rsv_en,
  input  logic [ADDR_W-1:0]        i_rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic                     o_rsv_ok,
  output logic [2**ADDR_W-1:0]     o_pending,
  output logic [NUM_RD-1:0]        o_rd_busy
);

  localparam logic [ADDR_W-1:0] PcA = ADDR_W'(PC_REG);

  logic [2**ADDR_W-1:0] r_pending;
  logic [2**ADDR_W-1:0] w_pend_clr;
  logic [2**ADDR_W-1:0] w_pend_d;
  logic [ADDR_W-1:0]    w_addr;

  // Retirement clears first so a register can be re-reserved in its retire cycle.
  always_comb begin
    w_pend_clr = r_pending;
    if (i_we && (i_wa != PcA)) begin
      w_pend_clr[i_wa] = 1'b0;
    end
    o_rsv_ok = i_rsv_en && !w_pend_clr[i_rsv_addr] && (i_rsv_addr != PcA);
    w_pend_d = w_pend_clr;
    if (o_rsv_ok) begin
      w_pend_d[i_rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pend_d;
    end
  end

  always_comb begin
    o_rd_busy = '0;
    w_addr    = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_addr = i_rd_addr[i*ADDR_W +: ADDR_W];
      if (w_addr == PcA) begin
        o_rd_busy[i] = 1'b0;
      end else if ((BYPASS != 0) && i_we && (i_wa == w_addr)) begin
        o_rd_busy[i] = 1'b0;
      end else begin
        o_rd_busy[i] = r_pending[w_addr];
      end
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with PC alias, optional write bypass and pending scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned PC_REG = (2 ** ADDR_W) - 1,
  parameter int unsigned BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        pc,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ok,
  output logic [2**ADDR_W-1:0]     pending,
  output logic                     stall
);

  localparam int unsigned       Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PcA   = ADDR_W'(PC_REG);

  logic [DATA_W-1:0] r_mem [Depth];
  logic [ADDR_W-1:0] w_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) begin
        r_mem[i] <= '0;
      end
    end else if (we && (wa != PcA)) begin
      r_mem[wa] <= wd;
    end
  end

  always_comb begin
    rd_data = '0;
    w_addr  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_addr = rd_addr[i*ADDR_W +: ADDR_W];
      if (w_addr == PcA) begin
        rd_data[i*DATA_W +: DATA_W] = pc;
      end else if ((BYPASS != 0) && we && (wa == w_addr)) begin
        rd_data[i*DATA_W +: DATA_W] = wd;
      end else begin
        rd_data[i*DATA_W +: DATA_W] = r_mem[w_addr];
      end
    end
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .PC_REG (PC_REG),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (we),
    .i_wa       (wa),
    .i_rsv_en   (rsv_en),
    .i_rsv_addr (rsv_addr),
    .i_rd_addr  (rd_addr),
    .o_rsv_ok   (rsv_ok),
    .o_pending  (pending),
    .o_rd_busy  (rd_busy)
  );

  assign stall = |(rd_en & rd_busy);

endmodule
